// File: rtl/median_window_feeder.sv
// median_window_feeder
//   Upstream stage of the 5-point median filter. It collects a stream of
//   samples into a sliding window of the last TAPS samples. Each complete
//   window is presented, packed, to the median core.
//
//   Handshakes (both sides): a transfer happens at a rising edge where
//   valid & ready are both high. A held window never changes while it
//   waits, and the sample side is stalled until the window is taken.
//
//   Optional build macro: REPLICATE_EDGE_EN
//     defined   - the first sample after reset/clear fills every slot (edge
//                 padding), so every input sample yields a window.
//     undefined - plain priming: the first TAPS-1 samples yield no window.
module median_window_feeder #(
    parameter int DATA_W = 8,
    parameter int TAPS   = 5,
    parameter int CNT_W  = 16,
    localparam int FILL_W = $clog2(TAPS + 1)
) (
    input  logic                     iClk,
    input  logic                     iReset_n,
    input  logic                     iClear,
    input  logic                     iValid,
    input  logic [DATA_W-1:0]        iSample,
    output logic                     oReady,
    output logic                     oWinValid,
    input  logic                     iWinReady,
    output logic [TAPS*DATA_W-1:0]   oWindow,
    output logic [FILL_W-1:0]        oFill,
    output logic [CNT_W-1:0]         oWinCount,
    output logic                     oStateRun
);

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state;
    state_t              stateNext;
    logic [DATA_W-1:0]   slots     [TAPS];
    logic [DATA_W-1:0]   slotsNext [TAPS];
    logic [FILL_W-1:0]   fillNext;
    logic                validNext;
    logic [CNT_W-1:0]    countNext;
    logic                accept;
    logic                consume;

    // Ready depends combinationally only on iWinReady; a pending window blocks intake.
    always_comb begin
        oReady  = ~oWinValid | iWinReady;
        accept  = iValid & oReady;
        consume = oWinValid & iWinReady;
    end

    // Next-state and datapath: clear dominates, then shift on accept, then consume.
    always_comb begin
        stateNext = state;
        fillNext  = oFill;
        validNext = oWinValid;
        countNext = oWinCount;
        for (int k = 0; k < TAPS; k++) slotsNext[k] = slots[k];

        if (iClear) begin
            stateNext = PRIME;
            fillNext  = '0;
            validNext = 1'b0;
            countNext = '0;
            for (int k = 0; k < TAPS; k++) slotsNext[k] = '0;
        end else begin
            if (consume) countNext = oWinCount + CNT_W'(1);
            if (accept) begin
                for (int k = TAPS - 1; k > 0; k--) slotsNext[k] = slots[k-1];
                slotsNext[0] = iSample;
                case (state)
                    PRIME: begin
`ifdef REPLICATE_EDGE_EN
                        for (int k = 0; k < TAPS; k++) slotsNext[k] = iSample;
                        fillNext  = FILL_W'(TAPS);
                        validNext = 1'b1;
                        stateNext = RUN;
`else
                        fillNext = oFill + FILL_W'(1);
                        if (oFill == FILL_W'(TAPS - 1)) begin
                            validNext = 1'b1;
                            stateNext = RUN;
                        end
`endif
                    end
                    RUN: begin
                        validNext = 1'b1;
                    end
                    default: begin
                        stateNext = PRIME;
                    end
                endcase
            end else if (consume) begin
                validNext = 1'b0;
            end
        end
    end

    // State register and datapath registers with asynchronous active-low reset.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state     <= PRIME;
            oFill     <= '0;
            oWinValid <= 1'b0;
            oWinCount <= '0;
            for (int k = 0; k < TAPS; k++) slots[k] <= '0;
        end else begin
            state     <= stateNext;
            oFill     <= fillNext;
            oWinValid <= validNext;
            oWinCount <= countNext;
            for (int k = 0; k < TAPS; k++) slots[k] <= slotsNext[k];
        end
    end

    // Pack the slots onto the window bus: slot 0 (newest) in the low bits.
    always_comb begin
        oWindow = '0;
        for (int k = 0; k < TAPS; k++) oWindow[k*DATA_W +: DATA_W] = slots[k];
        oStateRun = (state == RUN);
    end

endmodule

// File: tb/tb_median_window_feeder.sv
// Directed testbench for median_window_feeder (DATA_W=8, TAPS=5, CNT_W=16).
module tb_median_window_feeder;

  logic        iClk;
  logic        iReset_n;
  logic        iClear;
  logic        iValid;
  logic [7:0]  iSample;
  logic        oReady;
  logic        oWinValid;
  logic        iWinReady;
  logic [39:0] oWindow;
  logic [2:0]  oFill;
  logic [15:0] oWinCount;
  logic        oStateRun;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        clr;
    logic        vld;
    logic [7:0]  smp;
    logic        wrdy;
    logic        exp_rdy;
    logic        exp_valid;
    logic [39:0] exp_win;
    logic [2:0]  exp_fill;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];
  logic [39:0] exp_q[$];

  median_window_feeder #(.DATA_W(8), .TAPS(5), .CNT_W(16)) dut (
    .iClk(iClk), .iReset_n(iReset_n), .iClear(iClear), .iValid(iValid),
    .iSample(iSample), .oReady(oReady), .oWinValid(oWinValid),
    .iWinReady(iWinReady), .oWindow(oWindow), .oFill(oFill),
    .oWinCount(oWinCount), .oStateRun(oStateRun)
  );

  // clock / reset
  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  function automatic logic [39:0] pack5(input logic [7:0] s0, s1, s2, s3, s4);
    return {s4, s3, s2, s1, s0};
  endfunction

  function automatic vec_t mk(input logic clr, vld, input logic [7:0] smp, input logic wrdy,
                              input logic rdy, val, input logic [39:0] win,
                              input logic [2:0] fill, input logic [15:0] cnt);
    vec_t v;
    v.clr = clr; v.vld = vld; v.smp = smp; v.wrdy = wrdy;
    v.exp_rdy = rdy; v.exp_valid = val; v.exp_win = win;
    v.exp_fill = fill; v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: apply inputs, check comb ready before the edge, then sample after the edge
  task automatic drive(input logic clr, vld, input logic [7:0] smp, input logic wrdy,
                       input logic exp_rdy);
    iClear = clr; iValid = vld; iSample = smp; iWinReady = wrdy;
    #2;
    chk("ready", oReady, exp_rdy);
    @(posedge iClk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    drive(v.clr, v.vld, v.smp, v.wrdy, v.exp_rdy);
    chk($sformatf("v%0d valid", idx), oWinValid, v.exp_valid);
    chk($sformatf("v%0d window", idx), oWindow, v.exp_win);
    chk($sformatf("v%0d fill", idx), oFill, v.exp_fill);
    chk($sformatf("v%0d count", idx), oWinCount, v.exp_cnt);
  endtask

  initial begin
    logic [39:0] w;
    iReset_n = 1'b0; iClear = 1'b0; iValid = 1'b0; iSample = '0; iWinReady = 1'b0;
    #12;
    chk("rst valid", oWinValid, 1'b0);
    chk("rst window", oWindow, 40'h0);
    chk("rst fill", oFill, 3'd0);
    chk("rst count", oWinCount, 16'd0);
    chk("rst ready", oReady, 1'b1);
    iReset_n = 1'b1;

`ifdef REPLICATE_EDGE_EN
    // edge padding: first sample fills every slot
    vecs.push_back(mk(0, 1, 8'd7, 1, 1, 1, pack5(7, 7, 7, 7, 7), 3'd5, 16'd0));
    vecs.push_back(mk(0, 1, 8'd9, 1, 1, 1, pack5(9, 7, 7, 7, 7), 3'd5, 16'd1));
    vecs.push_back(mk(0, 0, 8'd0, 1, 1, 0, pack5(9, 7, 7, 7, 7), 3'd5, 16'd2));
    vecs.push_back(mk(1, 0, 8'd0, 0, 1, 0, 40'h0, 3'd0, 16'd0));
    vecs.push_back(mk(0, 1, 8'd3, 0, 1, 1, pack5(3, 3, 3, 3, 3), 3'd5, 16'd0));
    vecs.push_back(mk(0, 1, 8'd4, 0, 0, 1, pack5(3, 3, 3, 3, 3), 3'd5, 16'd0));
    vecs.push_back(mk(0, 1, 8'd4, 1, 1, 1, pack5(4, 3, 3, 3, 3), 3'd5, 16'd1));
    foreach (vecs[i]) run_vec(vecs[i], i);
`else
    // priming
    vecs.push_back(mk(0, 1, 8'd10, 1, 1, 0, pack5(10, 0, 0, 0, 0), 3'd1, 16'd0));
    vecs.push_back(mk(0, 1, 8'd20, 1, 1, 0, pack5(20, 10, 0, 0, 0), 3'd2, 16'd0));
    vecs.push_back(mk(0, 1, 8'd30, 1, 1, 0, pack5(30, 20, 10, 0, 0), 3'd3, 16'd0));
    vecs.push_back(mk(0, 1, 8'd40, 1, 1, 0, pack5(40, 30, 20, 10, 0), 3'd4, 16'd0));
    vecs.push_back(mk(0, 1, 8'd50, 1, 1, 1, pack5(50, 40, 30, 20, 10), 3'd5, 16'd0));
    // backpressure: window held for 3 cycles, then consume + accept together
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 1, 8'd60, 0, 0, 1, pack5(50, 40, 30, 20, 10), 3'd5, 16'd0));
    vecs.push_back(mk(0, 1, 8'd60, 1, 1, 1, pack5(60, 50, 40, 30, 20), 3'd5, 16'd1));
    vecs.push_back(mk(0, 0, 8'd0, 1, 1, 0, pack5(60, 50, 40, 30, 20), 3'd5, 16'd2));
    vecs.push_back(mk(0, 1, 8'd70, 0, 1, 1, pack5(70, 60, 50, 40, 30), 3'd5, 16'd2));
    // clear with a stalled window: discarded, not counted
    vecs.push_back(mk(1, 0, 8'd0, 0, 0, 0, 40'h0, 3'd0, 16'd0));
    vecs.push_back(mk(0, 1, 8'd1, 1, 1, 0, pack5(1, 0, 0, 0, 0), 3'd1, 16'd0));
    vecs.push_back(mk(0, 1, 8'd2, 1, 1, 0, pack5(2, 1, 0, 0, 0), 3'd2, 16'd0));
    vecs.push_back(mk(0, 1, 8'd3, 1, 1, 0, pack5(3, 2, 1, 0, 0), 3'd3, 16'd0));
    vecs.push_back(mk(0, 1, 8'd4, 1, 1, 0, pack5(4, 3, 2, 1, 0), 3'd4, 16'd0));
    vecs.push_back(mk(0, 1, 8'd5, 1, 1, 1, pack5(5, 4, 3, 2, 1), 3'd5, 16'd0));
    // clear dominates a simultaneous accept and consume
    vecs.push_back(mk(1, 1, 8'd99, 1, 1, 0, 40'h0, 3'd0, 16'd0));
    foreach (vecs[i]) run_vec(vecs[i], i);

    // continuous stream of 20 samples with the core always ready
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 8'(100 + i), 1, 1'b1);
      if (i >= 4) begin
        w = pack5(8'(100 + i), 8'(99 + i), 8'(98 + i), 8'(97 + i), 8'(96 + i));
        exp_q.push_back(w);
      end
      chk($sformatf("stream%0d valid", i), oWinValid, (i >= 4));
      chk($sformatf("stream%0d count", i), oWinCount, (i >= 5) ? 16'(i - 4) : 16'd0);
      if (exp_q.size() > 0) chk($sformatf("stream%0d window", i), oWindow, exp_q.pop_front());
    end
    drive(0, 0, 8'd0, 1, 1'b1);
    chk("stream final valid", oWinValid, 1'b0);
    chk("stream final count", oWinCount, 16'd16);
    chk("stream last window", oWindow, pack5(119, 118, 117, 116, 115));

    // reset mid-stream: no partial window afterwards
    drive(0, 1, 8'd200, 1, 1'b1);
    drive(0, 1, 8'd201, 1, 1'b1);
    iReset_n = 1'b0;
    #1;
    chk("midrst valid", oWinValid, 1'b0);
    chk("midrst fill", oFill, 3'd0);
    chk("midrst ready", oReady, 1'b1);
    iReset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 8'(i), 1, 1'b1);
      chk($sformatf("reprime%0d valid", i), oWinValid, 1'b0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
